// File: rtl/mem_access_stage.sv
// Memory-access stage: registers execute results, runs aligned 64-bit ld/sd over a req/ack bus, hands results to writeback.
// Optional feature: define MEM_TIMEOUT_EN to abort a WAIT that sees no ack within TIMEOUT_CYCLES cycles.
module mem_access_stage #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] ALUResult,
  input  logic [XLEN-1:0] WriteData,
  input  logic [4:0]      Rd,
  input  logic            MemRead,
  input  logic            MemWrite,
  input  logic            MemtoReg,
  input  logic            RegWrite,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] ReadDataOut,
  output logic [XLEN-1:0] ALUResultOut,
  output logic [4:0]      RdOut,
  output logic            MemtoRegOut,
  output logic            RegWriteOut,
  output logic            misalign_err,
  output logic            bus_err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] wdata;
    logic [4:0]      rd;
    logic            memtoreg;
    logic            regwrite;
    logic            we;
    logic            load;
    logic            misalign;
  } req_t;

  state_t          state_q, state_d;
  req_t            req_q;
  logic [XLEN-1:0] rdata_q;
  logic            bus_err_q;
  logic            accept, is_mem, misaligned, timeout_hit;

  assign accept     = in_valid & in_ready;
  assign is_mem     = MemRead | MemWrite;
  assign misaligned = is_mem & (|ALUResult[2:0]);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] to_cnt_q;
  // Fires on the TIMEOUT_CYCLES-th consecutive ack-less WAIT cycle; a same-cycle ack takes priority.
  assign timeout_hit = (state_q == WAIT) & ~mem_ack & (to_cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)                           to_cnt_q <= '0;
    else if (accept)                     to_cnt_q <= '0;
    else if (state_q == WAIT && !mem_ack) to_cnt_q <= to_cnt_q + 8'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (is_mem && !misaligned) ? WAIT : RESP;
      WAIT: if (mem_ack || timeout_hit) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rdata_q   <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.alu      <= ALUResult;
        req_q.wdata    <= WriteData;
        req_q.rd       <= Rd;
        req_q.memtoreg <= MemtoReg;
        req_q.regwrite <= RegWrite;
        req_q.we       <= MemWrite;              // ld+sd together behaves as a store
        req_q.load     <= MemRead & ~MemWrite;
        req_q.misalign <= misaligned;
        rdata_q        <= '0;
        bus_err_q      <= 1'b0;
      end
      if (state_q == WAIT && mem_ack && req_q.load) rdata_q <= mem_rdata;
      if (timeout_hit) bus_err_q <= 1'b1;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign mem_req      = (state_q == WAIT);
  assign mem_we       = mem_req & req_q.we;
  assign mem_addr     = mem_req ? req_q.alu   : '0;
  assign mem_wdata    = mem_req ? req_q.wdata : '0;
  assign out_valid    = (state_q == RESP);
  assign ReadDataOut  = rdata_q;
  assign ALUResultOut = req_q.alu;
  assign RdOut        = req_q.rd;
  assign MemtoRegOut  = req_q.memtoreg;
  assign RegWriteOut  = req_q.regwrite & ~req_q.misalign & ~bus_err_q;
  assign misalign_err = out_valid & req_q.misalign;
  assign bus_err      = out_valid & bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes expected writeback records, a monitor pops them on out_valid.
module tb_mem_access_stage;
  localparam int XLEN = 64;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic            clk = 1'b0, reset = 1'b1;
  logic            in_valid = 1'b0, in_ready;
  logic [XLEN-1:0] ALUResult = '0, WriteData = '0;
  logic [4:0]      Rd = '0;
  logic            MemRead = 1'b0, MemWrite = 1'b0, MemtoReg = 1'b0, RegWrite = 1'b0;
  logic            mem_req, mem_we, mem_ack = 1'b0;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic            out_valid, MemtoRegOut, RegWriteOut, misalign_err, bus_err;
  logic [XLEN-1:0] ReadDataOut, ALUResultOut;
  logic [4:0]      RdOut;

  mem_access_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .WriteData(WriteData), .Rd(Rd), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .ReadDataOut(ReadDataOut), .ALUResultOut(ALUResultOut), .RdOut(RdOut),
    .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut),
    .misalign_err(misalign_err), .bus_err(bus_err));

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] alu, rdata;
    logic [4:0]      rd;
    logic            m2r, rw, mis, be;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [XLEN-1:0] alu, rdata, input logic [4:0] rd,
                      input logic m2r, rw, mis, be);
    exp_t e;
    e.alu = alu; e.rdata = rdata; e.rd = rd; e.m2r = m2r; e.rw = rw; e.mis = mis; e.be = be;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid: got 1 want 0 (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ALUResultOut", ALUResultOut, e.alu);
        chk("ReadDataOut",  ReadDataOut,  e.rdata);
        chk("RdOut",        XLEN'(RdOut), XLEN'(e.rd));
        chk("MemtoRegOut",  XLEN'(MemtoRegOut),  XLEN'(e.m2r));
        chk("RegWriteOut",  XLEN'(RegWriteOut),  XLEN'(e.rw));
        chk("misalign_err", XLEN'(misalign_err), XLEN'(e.mis));
        chk("bus_err",      XLEN'(bus_err),      XLEN'(e.be));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic accept_op(input logic [XLEN-1:0] alu, wd, input logic [4:0] rd,
                           input logic mr, mw, m2r, rw);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin step(); n++; end
    chk("in_ready_before_accept", XLEN'(in_ready), 1);
    ALUResult = alu; WriteData = wd; Rd = rd;
    MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWrite = rw; in_valid = 1'b1;
    step();
    // Junk upstream values must not leak into the registered op.
    in_valid = 1'b0; ALUResult = '1; WriteData = '1; Rd = 5'h1f;
    MemRead = 1'b1; MemWrite = 1'b1; MemtoReg = 1'b0; RegWrite = 1'b1;
  endtask

  task automatic bus_ack(input int delay, input logic [XLEN-1:0] rdata, input logic we,
                         input logic [XLEN-1:0] addr, wdata);
    for (int i = 0; i < delay; i++) begin
      chk("mem_req_held", XLEN'(mem_req), 1);
      chk("mem_we",       XLEN'(mem_we),  XLEN'(we));
      chk("mem_addr",     mem_addr, addr);
      if (we) chk("mem_wdata", mem_wdata, wdata);
      chk("in_ready_busy", XLEN'(in_ready), 0);
      if (i == delay - 1) begin mem_ack = 1'b1; mem_rdata = rdata; end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    chk("mem_req_after_ack", XLEN'(mem_req), 0);
    chk("out_valid_after_ack", XLEN'(out_valid), 1);
    step();
    chk("out_valid_one_cycle", XLEN'(out_valid), 0);
    chk("in_ready_after_resp", XLEN'(in_ready), 1);
  endtask

  initial begin
    step(); step();
    chk("rst_in_ready",  XLEN'(in_ready),  1);
    chk("rst_mem_req",   XLEN'(mem_req),   0);
    chk("rst_out_valid", XLEN'(out_valid), 0);
    chk("rst_alu_out",   ALUResultOut, 0);
    chk("rst_rdata_out", ReadDataOut,  0);
    chk("rst_rw_out",    XLEN'(RegWriteOut), 0);
    reset = 1'b0;
    step();

    // ALU op: result one cycle after accept, no bus activity
    push(64'h2A, 0, 5, 0, 1, 0, 0);
    accept_op(64'h2A, 64'h0, 5, 0, 0, 0, 1);
    chk("alu_no_mem_req", XLEN'(mem_req), 0);
    chk("alu_out_valid",  XLEN'(out_valid), 1);
    step();
    chk("alu_out_valid_drop", XLEN'(out_valid), 0);

    // Load, ack on the third request cycle
    push(64'h100, 64'hDEADBEEF, 7, 1, 1, 0, 0);
    accept_op(64'h100, 64'h55, 7, 1, 0, 1, 1);
    bus_ack(3, 64'hDEADBEEF, 1'b0, 64'h100, 64'h0);

    // Store, immediate ack; rdata on the bus must not be captured
    push(64'h208, 0, 9, 0, 0, 0, 0);
    accept_op(64'h208, 64'h1234, 9, 0, 1, 0, 0);
    bus_ack(1, 64'hFFFF, 1'b1, 64'h208, 64'h1234);

    // Misaligned load: no request, error, writeback suppressed
    push(64'h103, 0, 3, 1, 0, 1, 0);
    accept_op(64'h103, 64'h0, 3, 1, 0, 1, 1);
    chk("mis_no_mem_req", XLEN'(mem_req), 0);
    chk("mis_out_valid",  XLEN'(out_valid), 1);
    step();

    // MemRead & MemWrite together act as a store
    push(64'h300, 0, 4, 1, 1, 0, 0);
    accept_op(64'h300, 64'hABCD, 4, 1, 1, 1, 1);
    bus_ack(2, 64'h777, 1'b1, 64'h300, 64'hABCD);

    // Stray ack while idle
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    chk("stray_ack_no_req",   XLEN'(mem_req), 0);
    chk("stray_ack_no_valid", XLEN'(out_valid), 0);
    step();

    // Reset during WAIT, then a late ack
    accept_op(64'h400, 64'h0, 6, 1, 0, 1, 1);
    chk("wait_mem_req", XLEN'(mem_req), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst_wait_mem_req",  XLEN'(mem_req), 0);
    chk("rst_wait_in_ready", XLEN'(in_ready), 1);
    chk("rst_wait_no_valid", XLEN'(out_valid), 0);
    mem_ack = 1'b1; mem_rdata = 64'hBAD; step(); mem_ack = 1'b0;
    chk("late_ack_no_valid", XLEN'(out_valid), 0);
    chk("late_ack_no_req",   XLEN'(mem_req), 0);
    step();

    // Stage still works after the mid-access reset
    push(64'h99, 0, 1, 0, 1, 0, 0);
    accept_op(64'h99, 64'h0, 1, 0, 0, 0, 1);
    chk("post_rst_out_valid", XLEN'(out_valid), 1);
    step();

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after TO request cycles
    push(64'h500, 0, 2, 1, 0, 0, 1);
    accept_op(64'h500, 64'h0, 2, 1, 0, 1, 1);
    for (int i = 0; i < TO; i++) begin
      chk("to_mem_req_held", XLEN'(mem_req), 1);
      step();
    end
    chk("to_mem_req_drop", XLEN'(mem_req), 0);
    chk("to_out_valid",    XLEN'(out_valid), 1);
    step();
    // Ack on the last allowed cycle wins over the timeout
    push(64'h508, 64'hCAFE, 2, 1, 1, 0, 0);
    accept_op(64'h508, 64'h0, 2, 1, 0, 1, 1);
    bus_ack(TO, 64'hCAFE, 1'b0, 64'h508, 64'h0);
`endif

    step(); step();
    chk("scoreboard_drained", XLEN'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
